// File: rtl/uart_xcmd.sv
// uart_xcmd: 8N1 UART receiver that parses ASCII hex digits and commits them to xcmd on CR/LF.
// Optional feature: define UART_XCMD_ECHO_EN to retransmit every valid received byte on tx.
module uart_xcmd #(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115_200,
    parameter logic [31:0] XCMD_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] xcmd,
    output logic        xcmd_stb,
    output logic        err_frame,
    output logic        err_cmd
);
    localparam int               CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1      = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [1:0]       rx_meta;
    logic             rx_sync;
    logic [1:0]       settle;
    logic             armed;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             rx_tick;
    logic             byte_valid;
    logic             frame_bad;
    logic [31:0]      shadow;
    logic [3:0]       count;
    logic             is_hex;
    logic             is_eol;
    logic [3:0]       nibble;

    assign rx_sync = rx_meta[1];

    // The synchroniser resets to 1, so its first outputs after reset are not real line
    // samples; settle keeps the receiver from arming until the pipeline holds true values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 2'b11;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= {rx_meta[0], rx};
            settle  <= {settle[0], 1'b1};
            if (frame_bad)
                armed <= 1'b0;
            else if (settle[1] && rx_sync)
                armed <= 1'b1;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_tick    = 1'b0;
        byte_valid = 1'b0;
        frame_bad  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (armed && !rx_sync)
                    rx_next = RX_START;
            end
            RX_START: begin
                rx_tick = (clk_cnt == HALF_M1);
                if (rx_tick)
                    rx_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                rx_tick = (clk_cnt == FULL_M1);
                if (rx_tick && bit_idx == 3'd7)
                    rx_next = RX_STOP;
            end
            RX_STOP: begin
                rx_tick = (clk_cnt == FULL_M1);
                if (rx_tick) begin
                    rx_next    = RX_IDLE;
                    byte_valid = rx_sync;
                    frame_bad  = !rx_sync;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            rx_shift  <= 8'h00;
            err_frame <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            clk_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : clk_cnt + 1'b1;
            err_frame <= frame_bad;
            if (rx_state == RX_START) begin
                bit_idx <= 3'd0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                bit_idx  <= bit_idx + 3'd1;
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
        end
    end

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        is_eol = (rx_shift == 8'h0D) || (rx_shift == 8'h0A);
        if (rx_shift >= 8'h30 && rx_shift <= 8'h39) begin
            is_hex = 1'b1;
            nibble = rx_shift[3:0];
        end else if ((rx_shift >= 8'h61 && rx_shift <= 8'h66) ||
                     (rx_shift >= 8'h41 && rx_shift <= 8'h46)) begin
            is_hex = 1'b1;
            nibble = rx_shift[3:0] + 4'd9;
        end
    end

    // Digits accumulate in shadow; xcmd only ever sees a complete committed word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xcmd     <= XCMD_RESET;
            xcmd_stb <= 1'b0;
            err_cmd  <= 1'b0;
            shadow   <= 32'h0;
            count    <= 4'd0;
        end else begin
            xcmd_stb <= 1'b0;
            err_cmd  <= 1'b0;
            if (frame_bad) begin
                shadow <= 32'h0;
                count  <= 4'd0;
            end else if (byte_valid) begin
                if (is_hex) begin
                    shadow <= {shadow[27:0], nibble};
                    count  <= (count == 4'd8) ? 4'd8 : count + 4'd1;
                end else if (is_eol) begin
                    if (count != 4'd0) begin
                        xcmd     <= shadow;
                        xcmd_stb <= 1'b1;
                        shadow   <= 32'h0;
                        count    <= 4'd0;
                    end
                end else begin
                    err_cmd <= 1'b1;
                    shadow  <= 32'h0;
                    count   <= 4'd0;
                end
            end
        end
    end

`ifdef UART_XCMD_ECHO_EN
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t        tx_state;
    tx_state_t        tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [7:0]       hold;
    logic             hold_full;
    logic             tx_tick;
    logic             tx_take;
    logic             tx_line_next;
    logic             tx_reg;

    always_comb begin
        tx_next      = tx_state;
        tx_tick      = (tx_cnt == FULL_M1);
        tx_take      = 1'b0;
        tx_line_next = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (hold_full) begin
                    tx_next = TX_START;
                    tx_take = 1'b1;
                end
            end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
        // The line is registered, so it is computed from the state being entered.
        case (tx_next)
            TX_START: tx_line_next = 1'b0;
            TX_DATA:  tx_line_next = (tx_state == TX_DATA && tx_tick) ? tx_shift[1] : tx_shift[0];
            default:  tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= 3'd0;
            tx_shift  <= 8'h00;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            tx_reg    <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_reg   <= tx_line_next;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_take) begin
                tx_shift <= hold;
                tx_bit   <= 3'd0;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
            if (byte_valid && (!hold_full || tx_take)) begin
                hold      <= rx_shift;
                hold_full <= 1'b1;
            end else if (tx_take) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign tx = tx_reg;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_xcmd.sv
// tb_uart_xcmd: table vectors, randomized bytes against a digit-queue model, and corner sequences.
module tb_uart_xcmd;
    localparam int          CLK_HZ   = 1_000_000;
    localparam int          BAUD     = 100_000;
    localparam int          BIT_CLKS = 10;
    localparam logic [31:0] XRST     = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        tx;
    logic [31:0] xcmd;
    logic        xcmd_stb;
    logic        err_frame;
    logic        err_cmd;

    int errors = 0;
    int checks = 0;
    int stb_seen = 0;
    int frame_seen = 0;
    int cmd_seen = 0;

    int          mq[$];
    logic [31:0] m_xcmd = XRST;
    int          m_stb = 0;
    int          m_frame = 0;
    int          m_cmd = 0;

    typedef struct {
        logic [7:0]  b;
        bit          stop_ok;
        logic [31:0] x;
        int          stb;
        int          frm;
        int          cmd;
    } vec_t;
    vec_t vecs[$];

    uart_xcmd #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .XCMD_RESET(XRST)) dut (
        .clock(clock), .reset(reset), .rx(rx), .tx(tx), .xcmd(xcmd),
        .xcmd_stb(xcmd_stb), .err_frame(err_frame), .err_cmd(err_cmd)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (xcmd_stb === 1'b1)  stb_seen++;
            if (err_frame === 1'b1) frame_seen++;
            if (err_cmd === 1'b1)   cmd_seen++;
        end
    end

`ifdef UART_XCMD_ECHO_EN
    logic [7:0] echo_q[$];
    int         echo_stop_bad = 0;

    always begin
        logic [7:0] d;
        @(negedge tx);
        repeat (BIT_CLKS / 2) @(negedge clock);
        if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clock);
                d[i] = tx;
            end
            repeat (BIT_CLKS) @(negedge clock);
            if (tx !== 1'b1) echo_stop_bad++;
            echo_q.push_back(d);
        end
    end
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        return -1;
    endfunction

    // Reference: keep at most the last 8 digits as a list; a commit evaluates them as a number.
    function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
        int v;
        if (!stop_ok) begin
            m_frame++;
            mq.delete();
            return;
        end
        v = hex_val(b);
        if (v >= 0) begin
            mq.push_back(v);
            if (mq.size() > 8) void'(mq.pop_front());
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (mq.size() > 0) begin
                m_xcmd = 32'h0;
                foreach (mq[k]) m_xcmd = m_xcmd * 32'd16 + 32'(mq[k]);
                m_stb++;
                mq.delete();
            end
        end else begin
            m_cmd++;
            mq.delete();
        end
    endfunction

    function automatic void add_vec(input logic [7:0] b, input bit ok, input logic [31:0] x,
                                    input int stb, input int frm, input int cmd);
        vec_t v;
        v.b = b; v.stop_ok = ok; v.x = x; v.stb = stb; v.frm = frm; v.cmd = cmd;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame; reset_bit >= 0 pulses reset inside that frame bit.
    task automatic applyStimulus(input logic [7:0] b, input bit stop_ok, input int reset_bit);
        for (int i = 0; i < 10; i++) begin
            rx = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
            if (i == reset_bit) begin
                repeat (2) @(negedge clock);
                reset = 1'b1;
                repeat (3) @(negedge clock);
                reset = 1'b0;
                repeat (BIT_CLKS - 5) @(negedge clock);
            end else begin
                repeat (BIT_CLKS) @(negedge clock);
            end
        end
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
    endtask

    task automatic check_totals(input string tag);
        checkOutput({tag, " xcmd"}, xcmd, m_xcmd);
        checkOutput({tag, " stb count"}, 32'(stb_seen), 32'(m_stb));
        checkOutput({tag, " frame count"}, 32'(frame_seen), 32'(m_frame));
        checkOutput({tag, " cmd count"}, 32'(cmd_seen), 32'(m_cmd));
    endtask

    initial begin
        string hs;
        int s0, f0, c0;
        logic [7:0] b;
        hs = "0123456789abcdefABCDEF";

        add_vec("6", 1, XRST, 0, 0, 0);
        add_vec("2", 1, XRST, 0, 0, 0);
        add_vec(8'h0D, 1, 32'h0000_0062, 1, 0, 0);
        for (int d = 1; d <= 9; d++) add_vec(8'(48 + d), 1, 32'h0000_0062, 0, 0, 0);
        add_vec(8'h0D, 1, 32'h2345_6789, 1, 0, 0);
        add_vec(8'h0A, 1, 32'h2345_6789, 0, 0, 0);
        add_vec("1", 1, 32'h2345_6789, 0, 0, 0);
        add_vec("g", 1, 32'h2345_6789, 0, 0, 1);
        add_vec(8'h0D, 1, 32'h2345_6789, 0, 0, 0);
        add_vec("A", 0, 32'h2345_6789, 0, 1, 0);
        add_vec("5", 1, 32'h2345_6789, 0, 0, 0);
        add_vec(8'h0D, 1, 32'h0000_0005, 1, 0, 0);

        repeat (4) @(negedge clock);
        checkOutput("reset xcmd", xcmd, XRST);
        checkOutput("reset xcmd_stb", 32'(xcmd_stb), 32'h0);
        checkOutput("reset err_frame", 32'(err_frame), 32'h0);
        checkOutput("reset err_cmd", 32'(err_cmd), 32'h0);
        checkOutput("reset tx", 32'(tx), 32'h1);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        foreach (vecs[i]) begin
            s0 = stb_seen; f0 = frame_seen; c0 = cmd_seen;
            applyStimulus(vecs[i].b, vecs[i].stop_ok, -1);
            model_byte(vecs[i].b, vecs[i].stop_ok);
            checkOutput($sformatf("vec%0d xcmd", i), xcmd, vecs[i].x);
            checkOutput($sformatf("vec%0d stb", i), 32'(stb_seen - s0), 32'(vecs[i].stb));
            checkOutput($sformatf("vec%0d err_frame", i), 32'(frame_seen - f0), 32'(vecs[i].frm));
            checkOutput($sformatf("vec%0d err_cmd", i), 32'(cmd_seen - c0), 32'(vecs[i].cmd));
`ifndef UART_XCMD_ECHO_EN
            checkOutput($sformatf("vec%0d tx idle", i), 32'(tx), 32'h1);
`endif
        end

        for (int n = 0; n < 40; n++) begin
            int r;
            bit ok;
            ok = 1'b1;
            r  = $urandom_range(0, 19);
            if (r <= 11 || r >= 18) begin
                b = hs[$urandom_range(0, 21)];
            end else if (r <= 13) begin
                b = 8'h0D;
            end else if (r == 14) begin
                b = 8'h0A;
            end else if (r <= 16) begin
                do b = 8'($urandom_range(0, 255));
                while (hex_val(b) >= 0 || b == 8'h0D || b == 8'h0A);
            end else begin
                b  = 8'($urandom_range(0, 255));
                ok = 1'b0;
            end
            applyStimulus(b, ok, -1);
            model_byte(b, ok);
            check_totals($sformatf("rnd%0d(%h)", n, b));
        end

        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clock);
        check_totals("glitch");

        applyStimulus("7", 1, 7);
        m_xcmd = XRST;
        mq.delete();
        checkOutput("midreset xcmd", xcmd, XRST);
        applyStimulus(8'h0D, 1, -1);
        model_byte(8'h0D, 1);
        check_totals("midreset CR");
        applyStimulus("7", 1, -1);
        model_byte("7", 1);
        applyStimulus(8'h0D, 1, -1);
        model_byte(8'h0D, 1);
        check_totals("after reset 7");
        checkOutput("after reset xcmd", xcmd, 32'h0000_0007);

`ifdef UART_XCMD_ECHO_EN
        repeat (30 * BIT_CLKS) @(negedge clock);
        echo_q.delete();
        echo_stop_bad = 0;
        applyStimulus("A", 1, -1);
        applyStimulus("B", 1, -1);
        applyStimulus(8'h0D, 1, -1);
        repeat (15 * BIT_CLKS) @(negedge clock);
        checkOutput("echo count", 32'(echo_q.size()), 32'd3);
        checkOutput("echo stop bits", 32'(echo_stop_bad), 32'd0);
        checkOutput("echo byte0", (echo_q.size() > 0) ? 32'(echo_q[0]) : 32'hFFFF_FFFF, 32'h41);
        checkOutput("echo byte1", (echo_q.size() > 1) ? 32'(echo_q[1]) : 32'hFFFF_FFFF, 32'h42);
        checkOutput("echo byte2", (echo_q.size() > 2) ? 32'(echo_q[2]) : 32'hFFFF_FFFF, 32'h0D);
`else
        checkOutput("tx tied high", 32'(tx), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
